// File: rtl/fb_ctrl_pkg.sv
// fb_pkg: shared types and helpers for the framebuffer controller.
// Contents: FB_AW (RAM address width), rgb8_t, fb_entry_t (queued pixel),
// fb_addr (builds {bank, v, h}) and back_bank (bank opposite the front one).
package fb_pkg;
  localparam int FB_AW = 17;
  typedef logic [7:0] rgb8_t;
  typedef struct packed {
    logic [7:0] v;
    logic [7:0] h;
    rgb8_t      rgb;
  } fb_entry_t;
  function automatic logic [FB_AW-1:0] fb_addr(input logic bank, input logic [7:0] v, input logic [7:0] h);
    return {bank, v, h};
  endfunction
  function automatic logic back_bank(input logic front);
    return ~front;
  endfunction
endpackage

// File: rtl/fb_ctrl_if.sv
// fb_ctrl_if: renderer, scan-out, RAM and status signals of fb_ctrl.
// master: controller side (drives vid_*, ram_addr/we/wdata, front, swap_pending, fifo_full).
// slave: environment side (drives wr_*, vblank, vid_rd/h/v, ram_rdata).
interface fb_ctrl_if;
  import fb_pkg::*;
  logic [7:0]       wr_h, wr_v;
  rgb8_t            wr_rgb;
  logic             wr_done, wr_frame, vblank, vid_rd;
  logic [7:0]       vid_h, vid_v;
  rgb8_t            vid_rgb;
  logic             vid_valid;
  logic [FB_AW-1:0] ram_addr;
  logic             ram_we;
  rgb8_t            ram_wdata, ram_rdata;
  logic             front, swap_pending, fifo_full;
  modport master(
    input  wr_h, wr_v, wr_rgb, wr_done, wr_frame, vblank, vid_rd, vid_h, vid_v, ram_rdata,
    output vid_rgb, vid_valid, ram_addr, ram_we, ram_wdata, front, swap_pending, fifo_full
  );
  modport slave(
    output wr_h, wr_v, wr_rgb, wr_done, wr_frame, vblank, vid_rd, vid_h, vid_v, ram_rdata,
    input  vid_rgb, vid_valid, ram_addr, ram_we, ram_wdata, front, swap_pending, fifo_full
  );
endinterface

// File: rtl/fb_wfifo.sv
// fb_wfifo: synchronous FIFO of fb_entry_t, DEPTH entries (power of two, >= 2).
// Ports: clk, reset (async, active-high), push/din, pop/dout (head, show-ahead),
// count, full, empty. A push while full is accepted when a pop happens in the same cycle.
module fb_wfifo import fb_pkg::*; #(parameter int DEPTH = 4) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  fb_entry_t                din,
  output fb_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  fb_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = count == ($clog2(DEPTH)+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + ($clog2(DEPTH)+1)'(do_push) - ($clog2(DEPTH)+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/fb_ctrl.sv
// fb_ctrl: double-buffered framebuffer controller sharing one single-port RAM.
// Ports: clk, reset (async, active-high), bus (fb_ctrl_if.master: renderer strobes,
// scan-out reads, RAM port, front/swap_pending/fifo_full status).
// Optional FB_DROP_CNT_EN: adds drop_cnt[15:0], a saturating count of dropped pushes.
// Scan-out reads always win the RAM port; queued writes go to the back bank and a
// fence holds the bank swap until every pixel queued before the frame event is written.
module fb_ctrl import fb_pkg::*; #(parameter int FIFO_DEPTH = 4) (
  input  logic        clk,
  input  logic        reset,
  fb_ctrl_if.master   bus
`ifdef FB_DROP_CNT_EN
  , output logic [15:0] drop_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic done_q, frame_q, push, frame_ev, pop, full, empty, swap, rd1, rd2;
  logic [CW-1:0] count, count_next, fence;
  fb_entry_t din, head;
  assign push       = bus.wr_done & ~done_q;
  assign frame_ev   = bus.wr_frame & ~frame_q;
  assign pop        = ~bus.vid_rd & ~empty;
  assign din        = {bus.wr_v, bus.wr_h, bus.wr_rgb};
  // fence reload uses the post-cycle count so a same-cycle push counts as pre-frame
  assign count_next = count + CW'(push & (~full | pop)) - CW'(pop);
  // a coinciding frame event merges into the pending swap instead of swapping now
  assign swap       = ~frame_ev & bus.swap_pending & bus.vblank & (fence == '0);
  assign bus.fifo_full = full;
  fb_wfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .dout(head),
    .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      done_q           <= 1'b0;
      frame_q          <= 1'b0;
      fence            <= '0;
      bus.front        <= 1'b0;
      bus.swap_pending <= 1'b0;
    end else begin
      done_q           <= bus.wr_done;
      frame_q          <= bus.wr_frame;
      fence            <= frame_ev ? count_next : (pop && fence != '0) ? fence - 1'b1 : fence;
      bus.swap_pending <= frame_ev | (bus.swap_pending & ~swap);
      bus.front        <= bus.front ^ swap;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.vid_rgb   <= '0;
      bus.vid_valid <= 1'b0;
      rd1           <= 1'b0;
      rd2           <= 1'b0;
    end else begin
      bus.ram_we    <= pop;
      bus.ram_addr  <= bus.vid_rd ? fb_addr(bus.front, bus.vid_v, bus.vid_h) :
                       pop ? fb_addr(back_bank(bus.front), head.v, head.h) : bus.ram_addr;
      if (pop) bus.ram_wdata <= head.rgb;
      rd1           <= bus.vid_rd;
      rd2           <= rd1;
      bus.vid_valid <= rd2;
      if (rd2) bus.vid_rgb <= bus.ram_rdata;
    end
`ifdef FB_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_cnt <= '0;
    else if (push & full & ~pop & ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_fb_ctrl.sv
// tb_fb_ctrl: self-checking bench for fb_ctrl against a queue-based reference model.
module tb_fb_ctrl;
  localparam int D = 4;
  typedef struct packed { logic [7:0] v, h, rgb; } px_t;
  logic clk = 1'b0;
  logic reset;
  fb_ctrl_if bus ();
`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  fb_ctrl #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef FB_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'd0};
  endfunction

  // external RAM: registered read, one cycle after the address
  logic [7:0] ram [0:131071];
  bit         ram_w [0:131071];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram[bus.ram_addr]   <= bus.ram_wdata;
      ram_w[bus.ram_addr] <= 1'b1;
    end
    bus.ram_rdata <= ram_w[bus.ram_addr] ? ram[bus.ram_addr] : pat(bus.ram_addr);
  end

  // reference model: pixel queue, frame barrier by sequence numbers, shadow memory
  logic [7:0] mm [0:131071];
  bit         mm_w [0:131071];
  px_t q[$];
  int qn, pushed, popped, barrier;
  logic m_front, m_pend, pd, pf, e_we, e_vv, s1v, s2v;
  logic [16:0] e_addr, s1a;
  logic [7:0] e_wd, e_rgb, s2r;
  logic [15:0] m_drop;
  logic m_push, m_fev, m_pop, m_acc, m_drp;
  assign m_push = bus.wr_done && !pd;
  assign m_fev  = bus.wr_frame && !pf;
  assign m_pop  = !bus.vid_rd && qn != 0;
  assign m_acc  = m_push && (qn < D || m_pop);
  assign m_drp  = m_push && !m_acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      qn <= 0; pushed <= 0; popped <= 0; barrier <= 0;
      m_front <= 0; m_pend <= 0; pd <= 0; pf <= 0;
      e_we <= 0; e_addr <= '0; e_wd <= '0; e_vv <= 0; e_rgb <= '0;
      s1v <= 0; s2v <= 0; s1a <= '0; s2r <= '0; m_drop <= '0;
    end else begin
      pd  <= bus.wr_done;
      pf  <= bus.wr_frame;
      s1v <= bus.vid_rd;
      s2v <= s1v;
      s2r <= mm_w[s1a] ? mm[s1a] : pat(s1a);
      e_vv <= s2v;
      if (s2v) e_rgb <= s2r;
      e_we <= m_pop;
      if (bus.vid_rd) begin
        e_addr <= {m_front, bus.vid_v, bus.vid_h};
        s1a    <= {m_front, bus.vid_v, bus.vid_h};
      end else if (m_pop) begin
        e_addr <= {~m_front, q[0].v, q[0].h};
        e_wd   <= q[0].rgb;
        mm[{~m_front, q[0].v, q[0].h}]   <= q[0].rgb;
        mm_w[{~m_front, q[0].v, q[0].h}] <= 1'b1;
        void'(q.pop_front());
      end
      if (m_acc) q.push_back('{bus.wr_v, bus.wr_h, bus.wr_rgb});
      if (m_drp && m_drop != 16'hFFFF) m_drop <= m_drop + 16'd1;
      qn     <= qn + int'(m_acc) - int'(m_pop);
      pushed <= pushed + int'(m_acc);
      popped <= popped + int'(m_pop);
      if (m_fev) begin
        m_pend  <= 1'b1;
        barrier <= pushed + int'(m_acc);
      end else if (m_pend && bus.vblank && popped >= barrier) begin
        m_front <= ~m_front;
        m_pend  <= 1'b0;
      end
    end
  end

  function automatic logic [37:0] dut_vec();
    return {bus.front, bus.swap_pending, bus.fifo_full, bus.ram_we, bus.ram_addr,
            bus.ram_wdata, bus.vid_valid, bus.vid_rgb};
  endfunction
  function automatic logic [37:0] exp_vec();
    return {m_front, m_pend, qn == D, e_we, e_addr, e_wd, e_vv, e_rgb};
  endfunction

  task automatic idle();
    bus.wr_done = 0; bus.wr_frame = 0; bus.vid_rd = 0; bus.vblank = 0;
    bus.wr_h = '0; bus.wr_v = '0; bus.wr_rgb = '0; bus.vid_h = '0; bus.vid_v = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== 38'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=0", dut_vec());
    end
`ifdef FB_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got=%h exp=0", drop_cnt); end
`endif
    reset = 0;
  endtask

  task automatic test_single_pixel();
    int seen = -1;
    @(negedge clk);
    bus.wr_done = 1; bus.wr_h = 8'h10; bus.wr_v = 8'h20; bus.wr_rgb = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_done = 0;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL single_model got=%h exp=%h", dut_vec(), exp_vec()); end
      if (bus.ram_we && seen < 0) begin
        seen = i;
        checks++;
        if (bus.ram_addr !== 17'h1_2010 || bus.ram_wdata !== 8'hA5) begin
          errors++; $display("FAIL single_write addr=%h data=%h exp addr=12010 data=a5", bus.ram_addr, bus.ram_wdata);
        end
      end
    end
    checks++;
    if (seen < 0 || seen > 1) begin errors++; $display("FAIL single_latency got=%0d exp<=1", seen); end
  endtask

  task automatic test_read_priority();
    int nv = 0, nw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL prio_model got=%h exp=%h", dut_vec(), exp_vec()); end
      nv += int'(bus.vid_valid); nw += int'(bus.ram_we);
      bus.vid_rd = 1; bus.vid_v = 8'h40; bus.vid_h = 8'(i * 3);
      bus.wr_done = (i % 2 == 0); bus.wr_h = 8'(i); bus.wr_v = 8'h50; bus.wr_rgb = 8'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL prio_model got=%h exp=%h", dut_vec(), exp_vec()); end
      nv += int'(bus.vid_valid); nw += int'(bus.ram_we);
    end
    checks++;
    if (nv != 4 || nw != 2) begin errors++; $display("FAIL prio_counts valid=%0d writes=%0d exp 4 2", nv, nw); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.vid_rd = 1; bus.vid_h = 8'($urandom); bus.vid_v = 8'($urandom);
      bus.wr_done = (i % 2 == 0); bus.wr_h = 8'($urandom); bus.wr_v = 8'($urandom); bus.wr_rgb = 8'($urandom);
    end
    @(negedge clk);
    bus.wr_done = 0;
    checks++;
    if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", bus.fifo_full); end
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ovf_model got=%h exp=%h", dut_vec(), exp_vec()); end
`ifdef FB_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ovf_drain got=%h exp=%h", dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_fence();
    int last_we = -1, flip = -1, nw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.vid_rd = 1; bus.vblank = 1;
      bus.wr_done = (i % 2 == 0); bus.wr_h = 8'(i); bus.wr_v = 8'h33; bus.wr_rgb = 8'($urandom);
    end
    @(negedge clk);
    bus.wr_done = 0; bus.wr_frame = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.swap_pending !== 1'b1 || bus.front !== 1'b0) begin
        errors++; $display("FAIL fence_hold pend=%b front=%b exp 1 0", bus.swap_pending, bus.front);
      end
    end
    bus.vid_rd = 0; bus.wr_frame = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL fence_model got=%h exp=%h", dut_vec(), exp_vec()); end
      if (bus.ram_we) begin last_we = i; nw++; end
      if (bus.front === 1'b1 && flip < 0) flip = i;
    end
    checks++;
    if (nw != 3 || flip != last_we + 1) begin
      errors++; $display("FAIL fence_swap writes=%0d last_we=%0d flip=%0d exp 3 writes, flip=last_we+1", nw, last_we, flip);
    end
  endtask

  task automatic test_no_vblank();
    @(negedge clk);
    idle();
    bus.wr_frame = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.swap_pending !== 1'b1 || bus.front !== 1'b1) begin
        errors++; $display("FAIL novb_hold pend=%b front=%b exp 1 1", bus.swap_pending, bus.front);
      end
    end
    bus.wr_frame = 0; bus.vblank = 1;
    @(negedge clk);
    checks++;
    if (bus.swap_pending !== 1'b0 || bus.front !== 1'b0) begin
      errors++; $display("FAIL novb_swap pend=%b front=%b exp 0 0", bus.swap_pending, bus.front);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
`ifdef FB_DROP_CNT_EN
      checks++;
      if (drop_cnt !== m_drop) begin errors++; $display("FAIL rand_drop got=%0d exp=%0d", drop_cnt, m_drop); end
`endif
      bus.vid_rd = ($urandom % 2) == 0; bus.vid_h = 8'($urandom); bus.vid_v = 8'($urandom);
      bus.wr_done = ($urandom % 3) == 0; bus.wr_h = 8'($urandom); bus.wr_v = 8'($urandom); bus.wr_rgb = 8'($urandom);
      bus.wr_frame = ($urandom % 12) == 0; bus.vblank = ($urandom % 4) == 0;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_read();
    int nv = 0;
    @(negedge clk);
    bus.vid_rd = 1; bus.vid_h = 8'h01; bus.vid_v = 8'h02;
    @(negedge clk);
    bus.vid_rd = 0; reset = 1;
    #1;
    checks++;
    if (dut_vec() !== 38'd0) begin errors++; $display("FAIL midrd_reset got=%h exp=0", dut_vec()); end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nv += int'(bus.vid_valid);
    end
    checks++;
    if (nv != 0 || dut_vec() !== 38'd0) begin errors++; $display("FAIL midrd_after valid=%0d state=%h exp 0 0", nv, dut_vec()); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_read_priority();
    test_overflow();
    test_fence();
    test_no_vblank();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
